muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M/RV64M multiply/divide execution unit for the EX stage of the pipelined CPU, beside the single-cycle ALU. It accepts one M-extension operation at a time on a start pulse and runs a shift-add multiply or restoring divide over XLEN cycles. It holds `busy_o` so the hazard unit stalls ID/EX, then presents the XLEN-bit result with a one-cycle `done_o` pulse.

## Interface
- `XLEN`, 32: operand and result width; any power of two ≥ 8.
- `CNT_W`, `$clog2(XLEN)`: iteration counter width (derived).

- `clk_i` input 1: clock.
- `rst_i` input 1: asynchronous, active-low reset.
- `start_i` input 1: request; accepted only in IDLE.
- `flush_i` input 1: synchronous abort from the pipeline flush.
- `funct3_i` input 3: M-op select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1_data_i` input XLEN: dividend / multiplicand.
- `rs2_data_i` input XLEN: divisor / multiplier.
- `busy_o` output 1: high whenever state ≠ IDLE.
- `done_o` output 1: one-cycle pulse; `result_o` is valid in this cycle.
- `result_o` output XLEN: result; held until the next accept.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: on `start_i` && !`flush_i`, register the op, the operand magnitudes, the sign flags and the special-case flag.
  - Special case: go directly to DONE.
  - Otherwise: go to CALC with counter = XLEN-1.
- CALC: one radix-2 step per cycle; counter decrements; go to FIX when the counter is 0.
  - Multiply: 2·XLEN accumulator, shift-add on unsigned magnitudes.
  - Divide: restoring division, XLEN-bit quotient and remainder.
- FIX: sign correction, then go to DONE.
  - Product is negated if the sign flag is set.
  - Quotient sign = sign(rs1) XOR sign(rs2). Remainder sign = sign(rs1).
  - MUL selects the product low half; MULH, MULHSU and MULHU select the high half.
- DONE: `done_o`=1 and `result_o` updated; go to IDLE.
- Signedness:
  - MULH, DIV, REM: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Special cases (no CALC/FIX):
  - Divide by zero: quotient = all ones; remainder = rs1.
  - Signed overflow (rs1 = −2^(XLEN-1), rs2 = −1): DIV returns rs1; REM returns 0.
- `start_i` outside IDLE is ignored, including in DONE; the requester must hold or re-issue it.
- `flush_i` in any state: go to IDLE next cycle with no `done_o`. It has priority over `start_i`, and `result_o` is unchanged.
- Reset (any time, including mid-CALC): state IDLE, `busy_o`=0, `done_o`=0, `result_o`=0, counter and accumulators 0.

## Timing
- Accept at edge t:
  - `busy_o` high from t+1.
  - Normal op: CALC occupies t+1..t+XLEN, FIX is t+XLEN+1, and `done_o`/`result_o` come at t+XLEN+2.
  - Special case: `done_o` at t+1.
- `busy_o` and `done_o` are both high in the DONE cycle. `busy_o` is low in the next cycle, when a new start can be accepted.
- Back-to-back throughput: one op per XLEN+3 cycles (normal path).
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `MULDIV_FAST_MUL_EN` defined:
  - MUL, MULH, MULHSU and MULHU use a single-cycle 2·XLEN multiplier in IDLE and go directly to DONE, so `done_o` comes at t+1.
  - Divides are unchanged.
- Undefined: all multiplies are iterative as described above.

## Structure
- Package `muldiv_pkg`: funct3 encodings for the eight M-ops; the state enum {IDLE, CALC, FIX, DONE}.
- Sub-module `muldiv_iter_core`, owning the datapath:
  - One-step shift-add and restore-subtract datapath: accumulator, quotient and remainder registers.
  - Control (`load_i`, `step_i`, `is_div_i`).
- The top level owns the FSM, counter, sign and special-case logic, and the result register.

## Test plan
- MUL 7 × −3 (XLEN=32): `result_o`=0xFFFFFFEB, `done_o` at accept+34; with `MULDIV_FAST_MUL_EN`, at accept+1.
- MULH 0x80000000 × 0x80000000 → 0x40000000; MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- DIV −7 / 2 → 0xFFFFFFFD; REM −7 / 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 / 7 → 2; each `done_o` at accept+34.
- DIVU 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5; DIV 0x80000000 / −1 → 0x80000000; REM 0x80000000 / −1 → 0; each `done_o` at accept+1.
- `flush_i` at CALC cycle 10 → `busy_o`=0 next cycle, no `done_o`, `result_o` unchanged. A following start completes correctly. `rst_i` low mid-CALC → all outputs 0 immediately.
- `start_i` held high across an op → exactly one `done_o`. The second op is accepted only in the cycle after DONE, and a start asserted in the DONE cycle is not accepted.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared definitions for the iterative RV32M/RV64M multiply/divide unit.
// funct3 encodings, the control FSM state type and signedness helpers.
package muldiv_pkg;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    // rs1 is treated as two's complement for MULH, MULHSU, DIV and REM
    function automatic logic op_rs1_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

    // rs2 is treated as two's complement for MULH, DIV and REM
    function automatic logic op_rs2_signed(input logic [2:0] f3);
        return (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: one radix-2 step per cycle on unsigned magnitudes.
// Multiply: shift-add into a 2*XLEN accumulator (multiplier in the low half).
// Divide: restoring division; quotient register doubles as the dividend shifter.
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              step_i,
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [2*XLEN-1:0] acc_o,
    output logic [XLEN-1:0]   quot_o,
    output logic [XLEN-1:0]   rem_o
);

    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_quot;
    logic [XLEN-1:0]   r_rem;
    logic [XLEN-1:0]   r_b;

    logic [XLEN:0]     w_sum;
    logic [XLEN:0]     w_shift;
    logic [XLEN:0]     w_diff;

    // Combinational step: add-if-lsb for multiply, trial subtract for divide
    always_comb begin
        w_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, (r_acc[0] ? r_b : {XLEN{1'b0}})};
        w_shift = {r_rem, r_quot[XLEN-1]};
        w_diff  = w_shift - {1'b0, r_b};
    end

    // Datapath registers: load operands, then advance one step per step_i
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_acc  <= '0;
            r_quot <= '0;
            r_rem  <= '0;
            r_b    <= '0;
        end else if (load_i) begin
            r_acc  <= {{XLEN{1'b0}}, a_i};
            r_quot <= a_i;
            r_rem  <= '0;
            r_b    <= b_i;
        end else if (step_i) begin
            if (is_div_i) begin
                // Borrow in the top bit means the trial subtract failed: restore
                if (!w_diff[XLEN]) begin
                    r_rem  <= w_diff[XLEN-1:0];
                    r_quot <= {r_quot[XLEN-2:0], 1'b1};
                end else begin
                    r_rem  <= w_shift[XLEN-1:0];
                    r_quot <= {r_quot[XLEN-2:0], 1'b0};
                end
            end else begin
                r_acc <= {w_sum, r_acc[XLEN-1:1]};
            end
        end
    end

    assign acc_o  = r_acc;
    assign quot_o = r_quot;
    assign rem_o  = r_rem;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative M-extension execution unit (IDLE -> CALC -> FIX -> DONE).
// Divide-by-zero and signed overflow finish straight from IDLE into DONE.
// Optional macro MULDIV_FAST_MUL_EN: multiplies use a single-cycle multiplier
// in IDLE and also go straight to DONE; divides are unaffected.
// Handshake: start_i is sampled only in IDLE (busy_o low); done_o is a one-cycle
// pulse with result_o valid; flush_i aborts any state back to IDLE without done_o.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output logic            busy_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [1:0]      dbg_state_o
);

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_e            r_state, w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [2:0]        r_op;
    logic              r_neg;
    logic [XLEN-1:0]   r_result;

    logic              w_neg1, w_neg2, w_is_div, w_div0, w_ovf, w_direct, w_load, w_step;
    logic [XLEN-1:0]   w_mag1, w_mag2, w_direct_val, w_fix_val, w_quot, w_rem;
    logic [2*XLEN-1:0] w_acc, w_prod;
`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fast_full, w_fast_signed;
`endif

    // Operand decode in IDLE: magnitudes, sign flags and special cases
    always_comb begin
        w_is_div     = funct3_i[2];
        w_neg1       = op_rs1_signed(funct3_i) && rs1_data_i[XLEN-1];
        w_neg2       = op_rs2_signed(funct3_i) && rs2_data_i[XLEN-1];
        w_mag1       = w_neg1 ? -rs1_data_i : rs1_data_i;
        w_mag2       = w_neg2 ? -rs2_data_i : rs2_data_i;
        w_div0       = w_is_div && (rs2_data_i == '0);
        w_ovf        = w_is_div && !funct3_i[0] && (rs1_data_i == MOST_NEG) && (rs2_data_i == '1);
        w_direct     = w_div0 || w_ovf;
        w_direct_val = '0;
        if (w_div0)      w_direct_val = funct3_i[1] ? rs1_data_i : '1;
        else if (w_ovf)  w_direct_val = funct3_i[1] ? '0 : rs1_data_i;
`ifdef MULDIV_FAST_MUL_EN
        w_fast_full   = {{XLEN{1'b0}}, w_mag1} * {{XLEN{1'b0}}, w_mag2};
        w_fast_signed = (w_neg1 ^ w_neg2) ? -w_fast_full : w_fast_full;
        if (!w_is_div) begin
            w_direct     = 1'b1;
            w_direct_val = (funct3_i == F3_MUL) ? w_fast_signed[XLEN-1:0]
                                                : w_fast_signed[2*XLEN-1:XLEN];
        end
`endif
    end

    // Sign correction and half/quotient/remainder selection in FIX
    always_comb begin
        w_prod    = r_neg ? -w_acc : w_acc;
        w_fix_val = '0;
        if (r_op[2])               w_fix_val = r_op[1] ? (r_neg ? -w_rem : w_rem)
                                                       : (r_neg ? -w_quot : w_quot);
        else if (r_op == F3_MUL)   w_fix_val = w_prod[XLEN-1:0];
        else                       w_fix_val = w_prod[2*XLEN-1:XLEN];
    end

    // Next-state and datapath control; flush wins over everything
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_step = 1'b0;
        if (flush_i) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE: if (start_i) begin
                    if (w_direct) begin
                        w_next = DONE;
                    end else begin
                        w_next = CALC;
                        w_load = 1'b1;
                    end
                end
                CALC: begin
                    w_step = 1'b1;
                    if (r_cnt == '0) w_next = FIX;
                end
                FIX:     w_next = DONE;
                DONE:    w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= IDLE;
        else        r_state <= w_next;
    end

    // Iteration counter, op and result-sign capture
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
            r_op  <= '0;
            r_neg <= 1'b0;
        end else if (w_load) begin
            r_cnt <= CNT_W'(XLEN - 1);
            r_op  <= funct3_i;
            r_neg <= (funct3_i[2] && funct3_i[1]) ? w_neg1 : (w_neg1 ^ w_neg2);
        end else if (w_step && r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Result register: written only on the transition into DONE
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_result <= '0;
        end else if (!flush_i) begin
            if (r_state == IDLE && start_i && w_direct) r_result <= w_direct_val;
            else if (r_state == FIX)                    r_result <= w_fix_val;
        end
    end

    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .load_i   (w_load),
        .step_i   (w_step),
        .is_div_i (r_op[2]),
        .a_i      (w_mag1),
        .b_i      (w_mag2),
        .acc_o    (w_acc),
        .quot_o   (w_quot),
        .rem_o    (w_rem)
    );

    assign busy_o      = (r_state != IDLE);
    assign done_o      = (r_state == DONE);
    assign result_o    = r_result;
    assign dbg_state_o = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed test-plan cases plus randomized ops against an
// arithmetic reference model (64-bit integer math on the RISC-V M rules).
module tb_muldiv_unit;

    localparam int XLEN = 32;
    localparam logic [31:0] MOST_NEG = 32'h8000_0000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = '0;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk_i       (clk),
        .rst_i       (rst_n),
        .start_i     (start),
        .flush_i     (flush),
        .funct3_i    (funct3),
        .rs1_data_i  (rs1),
        .rs2_data_i  (rs2),
        .busy_o      (busy),
        .done_o      (done),
        .result_o    (result),
        .dbg_state_o (dbg_state)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: RISC-V M semantics computed with wide integer arithmetic
    function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint          sp;
        longint unsigned up;
        int              sa, sb;
        sa = a;
        sb = b;
        case (f3)
            3'b000: begin up = longint'({32'b0, a}) * longint'({32'b0, b}); return up[31:0]; end
            3'b001: begin sp = longint'(sa) * longint'(sb); return sp[63:32]; end
            3'b010: begin sp = longint'(sa) * longint'({32'b0, b}); return sp[63:32]; end
            3'b011: begin up = longint'({32'b0, a}) * longint'({32'b0, b}); return up[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MOST_NEG && b == 32'hFFFF_FFFF) return a;
                return sa / sb;
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                if (a == MOST_NEG && b == 32'hFFFF_FFFF) return 32'h0;
                return sa % sb;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Expected accept-to-done distance in cycles
    function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (f3[2] && (b == 0)) return 1;
        if (f3[2] && !f3[0] && a == MOST_NEG && b == 32'hFFFF_FFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f3[2]) return 1;
`endif
        return XLEN + 2;
    endfunction

    // Driver: issue one op from IDLE, check busy, latency, result and return to IDLE
    task automatic run_op(input string name, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int k;
        int lat;
        logic [31:0] e;
        lat = ref_latency(f3, a, b);
        exp_q.push_back(exp);
        k = 0;
        while (busy && k < 200) begin @(negedge clk); k++; end
        funct3 = f3; rs1 = a; rs2 = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        k = 1;
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL %s busy_after_accept: got %b want 1", name, busy);
        end
        while (done !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        e = exp_q.pop_front();
        n_checks++;
        if (done !== 1'b1) begin
            n_errors++;
            $display("FAIL %s done_timeout: no done within %0d cycles", name, k);
        end else begin
            if (k != lat) begin
                n_errors++;
                $display("FAIL %s latency: got %0d want %0d", name, k, lat);
            end
            n_checks++;
            if (result !== e) begin
                n_errors++;
                $display("FAIL %s result: got %h want %h", name, result, e);
            end
            n_checks++;
            if (busy !== 1'b1) begin
                n_errors++;
                $display("FAIL %s busy_in_done: got %b want 1", name, busy);
            end
            last_exp = e;
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL %s after_done: busy=%b done=%b want 0 0", name, busy, done);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_release: busy=%b state=%0d want 0 0", busy, dbg_state);
        end
    endtask

    task automatic test_directed();
        run_op("mul_7_m3",      3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulh_min_min",  3'b001, MOST_NEG, MOST_NEG, 32'h4000_0000);
        run_op("mulhu_ff_ff",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("mulhsu_ff_ff",  3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("divu_100_7",    3'b101, 32'd100, 32'd7, 32'd14);
        run_op("remu_100_7",    3'b111, 32'd100, 32'd7, 32'd2);
    endtask

    task automatic test_special();
        run_op("divu_5_0",      3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("rem_5_0",       3'b110, 32'd5, 32'd0, 32'd5);
        run_op("div_ovf",       3'b100, MOST_NEG, 32'hFFFF_FFFF, MOST_NEG);
        run_op("rem_ovf",       3'b110, MOST_NEG, 32'hFFFF_FFFF, 32'd0);
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a, b;
        for (int i = 0; i < 40; i++) begin
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = MOST_NEG; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 15));
                3: a = MOST_NEG;
                default: ;
            endcase
            run_op($sformatf("rand%0d_f%0d", i, f3), f3, a, b, ref_result(f3, a, b));
        end
    endtask

    task automatic test_flush();
        int saw_done;
        funct3 = 3'b101; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_busy: got %b want 0", busy);
        end
        saw_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done++;
        end
        n_checks++;
        if (saw_done != 0 || result !== last_exp) begin
            n_errors++;
            $display("FAIL flush_quiet: done_count=%0d result=%h want 0 %h", saw_done, result, last_exp);
        end
        run_op("after_flush", 3'b101, 32'd1000, 32'd3, 32'd333);
    endtask

    task automatic test_reset_mid_calc();
        funct3 = 3'b100; rs1 = 32'hFFFF_FC00; rs2 = 32'd9; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_mid_calc: busy=%b done=%b result=%h want 0 0 0", busy, done, result);
        end
        @(negedge clk);
        rst_n = 1'b1;
        last_exp = 32'h0;
        @(negedge clk);
        run_op("after_reset", 3'b110, 32'hFFFF_FC00, 32'd9, ref_result(3'b110, 32'hFFFF_FC00, 32'd9));
    endtask

    task automatic test_back_to_back();
        int k;
        int gap;
        logic [31:0] e1, e2;
        e1 = ref_result(3'b101, 32'd5000, 32'd7);
        e2 = ref_result(3'b111, 32'd5000, 32'd7);
        funct3 = 3'b101; rs1 = 32'd5000; rs2 = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        k = 1;
        while (done !== 1'b1 && k < 200) begin @(negedge clk); k++; end
        n_checks++;
        if (done !== 1'b1 || k != XLEN + 2 || result !== e1) begin
            n_errors++;
            $display("FAIL b2b_first: done=%b at %0d result=%h want 1 at %0d %h", done, k, result, XLEN + 2, e1);
        end
        // Start stays high; operands switched in DONE must only take effect from the IDLE cycle
        funct3 = 3'b111;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_idle_gap: busy=%b done=%b want 0 0", busy, done);
        end
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL b2b_second_accept: busy=%b want 1", busy);
        end
        gap = 2;
        while (done !== 1'b1 && gap < 200) begin @(negedge clk); gap++; end
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || gap != XLEN + 3 || result !== e2) begin
            n_errors++;
            $display("FAIL b2b_second: done=%b gap=%0d result=%h want 1 %0d %h", done, gap, result, XLEN + 3, e2);
        end
        @(negedge clk);
        last_exp = e2;
        k = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done === 1'b1) k++;
        end
        n_checks++;
        if (busy !== 1'b0 || k != 0) begin
            n_errors++;
            $display("FAIL b2b_no_third: busy=%b extra_done=%0d want 0 0", busy, k);
        end
    endtask

    // Test sequence and final report
    initial begin
        test_reset();
        test_directed();
        test_special();
        test_flush();
        test_reset_mid_calc();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
